// File: rtl/vga_timing_if.sv
// Pixel-source handshake: the timing generator requests (pixel_x, pixel_y) with
// pixel_req, and the source returns pixel_data exactly REQ_LAT clocks later.
interface vga_timing_if #(
  parameter int RGB_W = 3
);
  logic             pixel_req;
  logic [9:0]       pixel_x;
  logic [9:0]       pixel_y;
  logic [RGB_W-1:0] pixel_data;

  modport master (output pixel_req, pixel_x, pixel_y, input pixel_data);
  modport slave  (input pixel_req, pixel_x, pixel_y, output pixel_data);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with look-ahead pixel requests, registered sync/DE/RGB
// outputs and built-in test patterns (white, checkerboard, black).
module vga_timing_gen #(
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_DISP    = 640,
  parameter int H_FRONT   = 16,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_DISP    = 480,
  parameter int V_FRONT   = 10,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int RGB_W     = 3,
  parameter int REQ_LAT   = 1,
  parameter int CHK_SHIFT = 5
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             timing_en,
  input  logic [1:0]       mode,
  vga_timing_if.master     pix,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             frame_start,
  output logic             line_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_SYNC_10 = 10'(H_SYNC);
  localparam logic [9:0]  V_SYNC_10 = 10'(V_SYNC);
  localparam logic [10:0] H_BEG_11  = 11'(H_START);
  localparam logic [10:0] H_END_11  = 11'(H_START + H_DISP);
  localparam logic [10:0] V_BEG_11  = 11'(V_START);
  localparam logic [10:0] V_END_11  = 11'(V_START + V_DISP);
  localparam logic [9:0]  CHK_MASK  = 10'(1) << CHK_SHIFT;

  logic [9:0]       cnt_h, cnt_v;
  logic [1:0]       mode_q;
  logic             h_act, v_act, act;
  logic [10:0]      p;
  logic             p_in_h;
  logic [9:0]       x_off, y_off;
  logic             chk_on;
  logic [RGB_W-1:0] colour;
  logic             at_origin;

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (!timing_en) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (cnt_h == H_LAST) begin
      cnt_h <= '0;
      cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
    end else begin
      cnt_h <= cnt_h + 10'd1;
    end
  end

  // Bounds are compared at 11 bits so an end-of-range equal to 1024 stays exact.
  assign h_act  = ({1'b0, cnt_h} >= H_BEG_11) && ({1'b0, cnt_h} < H_END_11);
  assign v_act  = ({1'b0, cnt_v} >= V_BEG_11) && ({1'b0, cnt_v} < V_END_11);
  assign act    = h_act && v_act;
  assign at_origin = (cnt_h == '0) && (cnt_v == '0);

  // Look-ahead position; past H_TOTAL-1 it lands outside the active range.
  assign p      = {1'b0, cnt_h} + 11'(REQ_LAT);
  assign p_in_h = (p >= H_BEG_11) && (p < H_END_11);

  assign pix.pixel_req = timing_en && p_in_h && v_act;
  assign pix.pixel_x   = pix.pixel_req ? 10'(p - H_BEG_11) : '0;
  assign pix.pixel_y   = pix.pixel_req ? 10'({1'b0, cnt_v} - V_BEG_11) : '0;

  assign x_off  = cnt_h - 10'(H_START);
  assign y_off  = cnt_v - 10'(V_START);
  assign chk_on = |((x_off ^ y_off) & CHK_MASK);

  // Mode only changes on frame boundaries so a frame is never mixed.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     mode_q <= 2'd0;
    else if (at_origin) mode_q <= mode;
  end

  always_comb begin
    colour = '0;
    case (mode_q)
      2'd0:    colour = pix.pixel_data;
      2'd1:    colour = '1;
      2'd2:    colour = chk_on ? '1 : '0;
      default: colour = '0;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (!timing_en) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      vga_rgb     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      vga_hs      <= (cnt_h < H_SYNC_10) ? HS_POL : ~HS_POL;
      vga_vs      <= (cnt_v < V_SYNC_10) ? VS_POL : ~VS_POL;
      vga_de      <= act;
      vga_rgb     <= act ? colour : '0;
      frame_start <= at_origin;
      line_start  <= (cnt_h == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced 25x11 raster (active 16x6 at (7,4)).
// Instance a: active-low syncs, REQ_LAT=2; instance b: active-high syncs, REQ_LAT=1.
module tb_vga_timing_gen;
  localparam int HT = 25;
  localparam int VT = 11;
  localparam int FT = HT * VT;

  // ---------------- clock / reset ----------------
  logic       vga_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       timing_en = 1'b0;
  logic [1:0] mode      = 2'd0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_if #(.RGB_W(3)) if_a ();
  vga_timing_if #(.RGB_W(3)) if_b ();

  logic       a_hs, a_vs, a_de, a_fs, a_ls;
  logic [2:0] a_rgb;
  logic       b_hs, b_vs, b_de, b_fs, b_ls;
  logic [2:0] b_rgb;

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(6),  .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .RGB_W(3), .REQ_LAT(2), .CHK_SHIFT(2)
  ) dut_a (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .timing_en(timing_en), .mode(mode),
    .pix(if_a), .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de), .vga_rgb(a_rgb),
    .frame_start(a_fs), .line_start(a_ls)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_DISP(16), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_DISP(6),  .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .RGB_W(3), .REQ_LAT(1), .CHK_SHIFT(2)
  ) dut_b (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .timing_en(timing_en), .mode(mode),
    .pix(if_b), .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de), .vga_rgb(b_rgb),
    .frame_start(b_fs), .line_start(b_ls)
  );

  // Pixel source for instance a: returns pixel_x[2:0] two clocks after the request.
  logic [2:0] src_d1 = '0;
  logic [2:0] src_d2 = '0;
  always @(posedge vga_clk) begin
    src_d1 <= if_a.pixel_x[2:0];
    src_d2 <= src_d1;
  end
  assign if_a.pixel_data = src_d2;
  assign if_b.pixel_data = '0;

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  int         pos   = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // After run() the time is 1 unit past a rising edge; the counters hold 'pos'
  // and the registered outputs describe the position one clock earlier.
  task automatic run(input int n);
    if (n > 0) begin
      repeat (n) @(posedge vga_clk);
      #1;
      pos = (pos + n) % FT;
    end
  endtask

  task automatic go_to(input int h, input int v);
    run(((v * HT + h) - pos + FT) % FT);
  endtask

  int de_cnt, ls_cnt, fs_cnt;

  initial begin
    #12;
    chk("rst_a_hs", a_hs, 1);
    chk("rst_a_vs", a_vs, 1);
    chk("rst_a_de", a_de, 0);
    chk("rst_a_rgb", a_rgb, 0);
    chk("rst_a_fs", a_fs, 0);
    chk("rst_a_ls", a_ls, 0);
    chk("rst_a_req", if_a.pixel_req, 0);
    chk("rst_b_hs", b_hs, 0);
    chk("rst_b_vs", b_vs, 0);

    sys_rst_n = 1'b1;
    timing_en = 1'b1;
    pos = 0;
    run(1);
    chk("clk1_ls", a_ls, 1);
    chk("clk1_fs", a_fs, 1);
    chk("clk1_hs", a_hs, 0);
    chk("clk1_vs", a_vs, 0);
    chk("clk1_de", a_de, 0);
    chk("clk1_b_hs", b_hs, 1);
    chk("clk1_b_vs", b_vs, 1);
    run(1);
    chk("clk2_ls", a_ls, 0);
    chk("clk2_fs", a_fs, 0);

    go_to(4, 0);  chk("hs_last_sync", a_hs, 0);
    go_to(5, 0);  chk("hs_after_sync", a_hs, 1); chk("b_hs_after_sync", b_hs, 0);
    go_to(0, 1);  chk("ls_line_end", a_ls, 0);   chk("hs_line_end", a_hs, 1);
    run(1);
    chk("ls_line1", a_ls, 1);
    chk("fs_line1", a_fs, 0);
    chk("hs_line1", a_hs, 0);
    chk("vs_line1", a_vs, 0);
    go_to(1, 2);  chk("vs_line2", a_vs, 1);      chk("b_vs_line2", b_vs, 0);

    go_to(4, 4);
    chk("req_before", if_a.pixel_req, 0);
    chk("x_before", if_a.pixel_x, 0);
    chk("y_before", if_a.pixel_y, 0);
    go_to(5, 4);
    chk("req_first", if_a.pixel_req, 1);
    chk("x_first", if_a.pixel_x, 0);
    chk("y_first", if_a.pixel_y, 0);
    chk("b_req_early", if_b.pixel_req, 0);
    go_to(6, 4);
    chk("b_req_first", if_b.pixel_req, 1);
    chk("b_x_first", if_b.pixel_x, 0);
    chk("x_second", if_a.pixel_x, 1);

    go_to(8, 4);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(3'(i % 8));
      chk("ext_de", a_de, 1);
      chk("ext_rgb", a_rgb, exp_q.pop_front());
      run(1);
    end
    chk("de_after_line", a_de, 0);
    chk("rgb_after_line", a_rgb, 0);

    go_to(20, 5);
    chk("req_last", if_a.pixel_req, 1);
    chk("x_last", if_a.pixel_x, 15);
    chk("y_row1", if_a.pixel_y, 1);
    go_to(21, 5); chk("req_end", if_a.pixel_req, 0); chk("x_end", if_a.pixel_x, 0);
    go_to(24, 5); chk("req_wrap_ahead", if_a.pixel_req, 0);
    go_to(5, 9);  chk("req_last_row", if_a.pixel_req, 1); chk("y_last_row", if_a.pixel_y, 5);
    go_to(5, 10); chk("req_below", if_a.pixel_req, 0);    chk("y_below", if_a.pixel_y, 0);

    go_to(0, 6);
    mode = 2'd2;
    go_to(10, 7); chk("mode_held_ext", a_rgb, 2);
    go_to(8, 4);
    chk("chk_00", a_rgb, 0);
    chk("chk_00_de", a_de, 1);
    chk("chk_req", if_a.pixel_req, 1);
    go_to(12, 4); chk("chk_40", a_rgb, 7);
    go_to(8, 8);  chk("chk_04", a_rgb, 7);
    go_to(12, 8); chk("chk_44", a_rgb, 0);
    mode = 2'd1;
    go_to(8, 4);  chk("white_px", a_rgb, 7);
    go_to(24, 4); chk("white_blank_de", a_de, 0); chk("white_blank_rgb", a_rgb, 0);
    mode = 2'd3;
    go_to(12, 4); chk("black_px", a_rgb, 0); chk("black_de", a_de, 1);

    go_to(0, 0);
    de_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      run(1);
      de_cnt += int'(a_de);
      ls_cnt += int'(a_ls);
      fs_cnt += int'(a_fs);
    end
    chk("de_per_frame", de_cnt, 96);
    chk("ls_per_frame", ls_cnt, 11);
    chk("fs_per_frame", fs_cnt, 1);

    go_to(15, 6);
    timing_en = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("dis_hs", a_hs, 1);
    chk("dis_vs", a_vs, 1);
    chk("dis_de", a_de, 0);
    chk("dis_rgb", a_rgb, 0);
    chk("dis_ls", a_ls, 0);
    chk("dis_fs", a_fs, 0);
    chk("dis_req", if_a.pixel_req, 0);
    chk("dis_x", if_a.pixel_x, 0);
    chk("dis_b_hs", b_hs, 0);
    repeat (8) @(posedge vga_clk);
    #1;
    timing_en = 1'b1;
    pos = 0;
    run(1);
    chk("reen_ls", a_ls, 1);
    chk("reen_fs", a_fs, 1);
    chk("reen_hs", a_hs, 0);
    go_to(5, 4);  chk("reen_req", if_a.pixel_req, 1);

    go_to(10, 5);
    sys_rst_n = 1'b0;
    #1;
    chk("arst_de", a_de, 0);
    chk("arst_hs", a_hs, 1);
    chk("arst_vs", a_vs, 1);
    chk("arst_req", if_a.pixel_req, 0);
    sys_rst_n = 1'b1;
    pos = 0;
    run(1);
    chk("rel_fs", a_fs, 1);
    chk("rel_ls", a_ls, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
